// File: rtl/misr_response_compactor_if.sv
// Response-vector handshake between a netlist under test and the compactor.
//   resp_valid : response vector valid (master -> slave)
//   resp_data  : WIDTH-bit response vector (master -> slave)
//   resp_ready : compactor accepts a beat (slave -> master)
interface misr_response_compactor_if #(
   parameter int unsigned WIDTH = 23
);
   logic             resp_valid;
   logic [WIDTH-1:0] resp_data;
   logic             resp_ready;

   modport master (output resp_valid, output resp_data, input resp_ready);
   modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/misr_response_compactor.sv
// MISR response compactor: folds one response vector per accepted beat into a
// multiple-input signature register, then compares against a golden value.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start, abort    : run request (IDLE/DONE only), cancel (CAPTURE/CHECK only)
//   num_patterns    : beats to compact, latched on accepted start
//   expected_sig    : golden signature, latched on accepted start
//   resp            : response handshake (slave side)
//   busy/done/pass  : run status; pass valid while done=1
//   signature/count : current MISR contents and beats accepted this run
module misr_response_compactor #(
   parameter int unsigned      WIDTH = 23,
   parameter int unsigned      CNT_W = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(23'h000021),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(23'h000000)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [CNT_W-1:0]         num_patterns,
   input  logic [WIDTH-1:0]         expected_sig,
   misr_response_compactor_if.slave resp,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [WIDTH-1:0]         signature,
   output logic [CNT_W-1:0]         count
);

   typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DONE} state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] target;
   logic [WIDTH-1:0] exp_q;
   logic             ready_q;
   logic             beat_c;
   logic             start_acc_c;
   logic             last_beat_c;
   logic [WIDTH-1:0] sig_next_c;

   assign resp.resp_ready = ready_q;

   // ready_q is high exactly while in CAPTURE, so it qualifies the handshake
   assign beat_c      = resp.resp_valid & ready_q;
   assign start_acc_c = start & ((state == IDLE) | (state == DONE));
   assign last_beat_c = beat_c & (count == (target - CNT_W'(1)));
   assign sig_next_c  = {signature[WIDTH-2:0], 1'b0}
                        ^ (signature[WIDTH-1] ? POLY : WIDTH'(0))
                        ^ resp.resp_data;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Next-state logic; abort outranks the CAPTURE->CHECK transition
   always_comb begin
      state_d = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_d = (num_patterns == CNT_W'(0)) ? CHECK : CAPTURE;
         end
         CAPTURE: begin
            if (abort)            state_d = IDLE;
            else if (last_beat_c) state_d = CHECK;
         end
         CHECK: begin
            state_d = abort ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered status outputs (decoded from the next state)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         signature <= SEED;
         count     <= '0;
         target    <= '0;
         exp_q     <= '0;
         pass      <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         ready_q <= (state_d == CAPTURE);
         busy    <= (state_d == CAPTURE) | (state_d == CHECK);
         done    <= (state_d == DONE);
         if (start_acc_c) begin
            target    <= num_patterns;
            exp_q     <= expected_sig;
            signature <= SEED;
            count     <= '0;
            pass      <= 1'b0;
         end else if (beat_c) begin
            signature <= sig_next_c;
            count     <= count + CNT_W'(1);
         end
         // pass already 0 since start, so an aborted CAPTURE leaves it cleared
         if (state == CHECK) pass <= ~abort & (signature == exp_q);
      end
   end

endmodule

// File: tb/tb_misr_response_compactor.sv
module tb_misr_response_compactor;

   localparam int unsigned W = 23;
   localparam int unsigned C = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort;
   logic [C-1:0]  num_patterns;
   logic [W-1:0]  expected_sig;
   logic          busy, done, pass;
   logic [W-1:0]  signature;
   logic [C-1:0]  count;

   int tests = 0;
   int fails = 0;

   misr_response_compactor_if #(.WIDTH(W)) bus ();

   misr_response_compactor dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .num_patterns (num_patterns),
      .expected_sig (expected_sig),
      .resp         (bus),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .signature    (signature),
      .count        (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sig;
      logic [C-1:0] cnt;
   } sb_t;

   typedef struct {
      int unsigned       n;
      logic [3:0][W-1:0] data;
      logic [W-1:0]      exp_in;
      logic [W-1:0]      sig;
      logic              pass;
   } vec_t;

   sb_t          sbq[$];
   logic [W-1:0] m_sig;
   logic [C-1:0] m_cnt;

   function automatic logic [W-1:0] step(input logic [W-1:0] s, input logic [W-1:0] d);
      return {s[W-2:0], 1'b0} ^ (s[W-1] ? 23'h000021 : 23'h000000) ^ d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: compare every observed handshake against the queued model result
   always @(posedge clk) begin
      if (!rst && bus.resp_valid && bus.resp_ready) begin
         sb_t e;
         #1;
         if (sbq.size() == 0) begin
            chk("unexpected_beat", 32'(count), 32'hFFFF_FFFF);
         end else begin
            e = sbq.pop_front();
            chk("beat_sig", 32'(signature), 32'(e.sig));
            chk("beat_cnt", 32'(count), 32'(e.cnt));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input int unsigned n, input logic [W-1:0] e);
      start        = 1'b1;
      num_patterns = C'(n);
      expected_sig = e;
      @(negedge clk);
      start = 1'b0;
      m_sig = '0;
      m_cnt = '0;
   endtask

   task automatic beat(input logic [W-1:0] d, input int gaps);
      int waited = 0;
      while (bus.resp_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) chk("ready_timeout", 32'(bus.resp_ready), 32'd1);
      bus.resp_valid = 1'b1;
      bus.resp_data  = d;
      m_sig = step(m_sig, d);
      m_cnt = m_cnt + C'(1);
      sbq.push_back('{sig: m_sig, cnt: m_cnt});
      @(negedge clk);
      bus.resp_valid = 1'b0;
      repeat (gaps) @(negedge clk);
   endtask

   // Called at the negedge following the final beat edge (CHECK cycle)
   task automatic finish_check(input string tag, input logic [W-1:0] s, input logic p);
      chk({tag, "_check_done"}, 32'(done), 32'd0);
      chk({tag, "_check_ready"}, 32'(bus.resp_ready), 32'd0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_sig"}, 32'(signature), 32'(s));
      chk({tag, "_pass"}, 32'(pass), 32'(p));
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{n: 1, data: {23'h0, 23'h0, 23'h0, 23'h000001}, exp_in: 23'h000001, sig: 23'h000001, pass: 1'b1};
      vecs[1] = '{n: 2, data: {23'h0, 23'h0, 23'h000000, 23'h400000}, exp_in: 23'h000021, sig: 23'h000021, pass: 1'b1};
      vecs[2] = '{n: 2, data: {23'h0, 23'h0, 23'h000000, 23'h400000}, exp_in: 23'h000020, sig: 23'h000021, pass: 1'b0};
      vecs[3] = '{n: 0, data: {23'h0, 23'h0, 23'h0, 23'h0}, exp_in: 23'h000000, sig: 23'h000000, pass: 1'b1};
      vecs[4] = '{n: 3, data: {23'h0, 23'h000004, 23'h000002, 23'h000001}, exp_in: 23'h000004, sig: 23'h000004, pass: 1'b1};
      vecs[5] = '{n: 4, data: {23'h000001, 23'h000000, 23'h400000, 23'h400000}, exp_in: 23'h0000C7, sig: 23'h0000C7, pass: 1'b1};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      num_patterns = '0; expected_sig = '0;
      bus.resp_valid = 1'b0; bus.resp_data = '0;
      m_sig = '0; m_cnt = '0;
      #1;
      chk("rst_sig", 32'(signature), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_status", {29'd0, busy, done, pass}, 32'd0);
      chk("rst_ready", 32'(bus.resp_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven runs
      foreach (vecs[i]) begin
         do_start(vecs[i].n, vecs[i].exp_in);
         chk("start_busy", 32'(busy), 32'd1);
         if (vecs[i].n == 0) chk("zero_ready", 32'(bus.resp_ready), 32'd0);
         for (int b = 0; b < int'(vecs[i].n); b++) begin
            if (b == 0 && vecs[i].n == 2 && vecs[i].data[0] == 23'h400000) begin
               beat(vecs[i].data[b], 0);
               chk("first_beat_sig", 32'(signature), 32'h400000);
            end else begin
               beat(vecs[i].data[b], 0);
            end
         end
         finish_check($sformatf("vec%0d", i), vecs[i].sig, vecs[i].pass);
         @(negedge clk);
      end

      // Gapped beats, mid-run start ignored, idle valid ignored
      do_start(3, 23'h000004);
      beat(23'h000001, 2);
      chk("gap_cnt1", 32'(count), 32'd1);
      start = 1'b1; num_patterns = C'(1); expected_sig = 23'h7FFFFF;
      @(negedge clk);
      start = 1'b0;
      chk("midstart_busy", 32'(busy), 32'd1);
      chk("midstart_cnt", 32'(count), 32'd1);
      beat(23'h000002, 2);
      chk("gap_cnt2", 32'(count), 32'd2);
      beat(23'h000004, 0);
      finish_check("gap", 23'h000004, 1'b1);
      bus.resp_valid = 1'b1; bus.resp_data = 23'h155555;
      repeat (2) @(negedge clk);
      bus.resp_valid = 1'b0;
      chk("idle_valid_sig", 32'(signature), 32'h000004);
      chk("idle_valid_cnt", 32'(count), 32'd3);
      chk("done_held", 32'(done), 32'd1);

      // Abort after 2 of 5 beats, then a clean rerun
      do_start(5, 23'h0);
      beat(23'h000011, 0);
      beat(23'h000022, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_count", 32'(count), 32'd2);
      chk("abort_sig", 32'(signature), 32'(step(23'h000011, 23'h000022)));
      chk("abort_ready", 32'(bus.resp_ready), 32'd0);
      do_start(1, 23'h000001);
      beat(23'h000001, 0);
      finish_check("rerun", 23'h000001, 1'b1);

      // Start and abort together in DONE: start wins
      start = 1'b1; abort = 1'b1; num_patterns = C'(2); expected_sig = 23'h0;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      m_sig = '0; m_cnt = '0;
      chk("startabort_busy", 32'(busy), 32'd1);
      chk("startabort_done", 32'(done), 32'd0);

      // Abort on the final beat: beat compacted, FSM goes to IDLE
      beat(23'h000003, 0);
      abort = 1'b1;
      beat(23'h000005, 0);
      abort = 1'b0;
      chk("lastabort_busy", 32'(busy), 32'd0);
      chk("lastabort_done", 32'(done), 32'd0);
      chk("lastabort_cnt", 32'(count), 32'd2);
      chk("lastabort_sig", 32'(signature), 32'(step(23'h000003, 23'h000005)));
      @(negedge clk);
      chk("lastabort_stay_idle", 32'(done), 32'd0);

      // Asynchronous reset mid-CAPTURE
      do_start(5, 23'h0);
      beat(23'h000007, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_sig", 32'(signature), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_status", {29'd0, busy, done, pass}, 32'd0);
      chk("arst_ready", 32'(bus.resp_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_idle_busy", 32'(busy), 32'd0);
      chk("arst_idle_ready", 32'(bus.resp_ready), 32'd0);

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
